// File: rtl/msk_and_hpc2_pipe.sv
// msk_and_hpc2_pipe: W-lane, d-share HPC2 masked AND (PINI at order d-1) wrapped in a
// two-stage valid/ready pipeline with a separate randomness handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand sharings valid
//   in_ready   block accepts operands this cycle
//   ina, inb   operand sharings, share i at bits [i*W +: W]
//   rnd_valid  fresh randomness available
//   rnd_ready  randomness consumed this cycle (only together with an operand transfer)
//   rnd        lane k at bits [k*hpc2rnd +: hpc2rnd], pair (i<j) at i*d - i*(i+1)/2 + (j-1-i)
//   out_valid  result sharing valid
//   out_ready  downstream accepts result
//   out        sharing of a & b, same layout as ina
//
// Optional build macro MSK_HPC2_CLEAR_EN: stage data registers are zeroed whenever their
// contents move on without a new load, so out reads 0 while out_valid is 0.
module msk_and_hpc2_pipe #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [d*W-1:0]           ina,
  input  logic [d*W-1:0]           inb,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  input  logic [W*(d*(d-1)/2)-1:0] rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [d*W-1:0]           out
);
  localparam int unsigned hpc2rnd = d * (d - 1) / 2;

  // Index of the random bit shared by shares x and y (order-independent).
  function automatic int unsigned pair_idx(input int unsigned x, input int unsigned y);
    int unsigned lo, hi;
    lo = (x < y) ? x : y;
    hi = (x < y) ? y : x;
    return lo * d - lo * (lo + 1) / 2 + (hi - 1 - lo);
  endfunction

  logic fire_in, fire_out, adv_a;
  logic va_q, va_d, vb_q, vb_d;

  // r_pair[i][j] == r_pair[j][i]; the diagonal is unused and tied to zero.
  logic [W-1:0]   r_pair [d][d];

  logic [d*W-1:0] a_a_q, b_a_q;
  logic [W-1:0]   v_a_q [d][d];
  logic [W-1:0]   r_a_q [d][d];

  logic [W-1:0]   u_b_q [d][d];
  logic [W-1:0]   w_b_q [d][d];
  logic [d*W-1:0] p_b_q;

  assign fire_out  = vb_q & out_ready;
  assign adv_a     = va_q & (~vb_q | fire_out);
  assign in_ready  = rnd_valid & (~va_q | adv_a);
  assign fire_in   = in_valid & in_ready;
  assign rnd_ready = fire_in;
  assign out_valid = vb_q;

  always_comb begin
    va_d = va_q;
    if (fire_in) begin
      va_d = 1'b1;
    end else if (adv_a) begin
      va_d = 1'b0;
    end
    vb_d = vb_q;
    if (adv_a) begin
      vb_d = 1'b1;
    end else if (fire_out) begin
      vb_d = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        r_pair[i][j] = '0;
        if (i != j) begin
          for (int unsigned k = 0; k < W; k++) begin
            r_pair[i][j][k] = rnd[k * hpc2rnd + pair_idx(i, j)];
          end
        end
      end
    end
  end

  // Valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
    end
  end

  // Stage A: blinded cross-domain operand and the randomness used to blind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_a_q <= '0;
      b_a_q <= '0;
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          v_a_q[i][j] <= '0;
          r_a_q[i][j] <= '0;
        end
      end
    end else if (fire_in) begin
      a_a_q <= ina;
      b_a_q <= inb;
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          v_a_q[i][j] <= inb[j*W +: W] ^ r_pair[i][j];
          r_a_q[i][j] <= r_pair[i][j];
        end
      end
    end
`ifdef MSK_HPC2_CLEAR_EN
    else if (adv_a) begin
      a_a_q <= '0;
      b_a_q <= '0;
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          v_a_q[i][j] <= '0;
          r_a_q[i][j] <= '0;
        end
      end
    end
`endif
  end

  // Stage B: share i is only ever combined with its own a_i, keeping domains separate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_b_q <= '0;
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          u_b_q[i][j] <= '0;
          w_b_q[i][j] <= '0;
        end
      end
    end else if (adv_a) begin
      for (int unsigned i = 0; i < d; i++) begin
        p_b_q[i*W +: W] <= a_a_q[i*W +: W] & b_a_q[i*W +: W];
        for (int unsigned j = 0; j < d; j++) begin
          u_b_q[i][j] <= ~a_a_q[i*W +: W] & r_a_q[i][j];
          w_b_q[i][j] <= a_a_q[i*W +: W] & v_a_q[i][j];
        end
      end
    end
`ifdef MSK_HPC2_CLEAR_EN
    else if (fire_out) begin
      p_b_q <= '0;
      for (int unsigned i = 0; i < d; i++) begin
        for (int unsigned j = 0; j < d; j++) begin
          u_b_q[i][j] <= '0;
          w_b_q[i][j] <= '0;
        end
      end
    end
`endif
  end

  // Output compression reads stage B registers only.
  always_comb begin
    out = p_b_q;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        if (i != j) begin
          out[i*W +: W] = out[i*W +: W] ^ u_b_q[i][j] ^ w_b_q[i][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Self-checking bench for msk_and_hpc2_pipe: a d=2/W=4 instance for handshake, latency,
// stall and reset sequences, and a d=3/W=2 instance for exhaustive unmasked values.
module tb_msk_and_hpc2_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid2, in_ready2, rnd_valid2, rnd_ready2, out_valid2, out_ready2;
  logic [7:0] ina2, inb2, out2;
  logic [3:0] rnd2;

  logic       in_valid3, in_ready3, rnd_valid3, rnd_ready3, out_valid3, out_ready3;
  logic [5:0] ina3, inb3, rnd3, out3;

  msk_and_hpc2_pipe #(.d(2), .W(4)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .ina(ina2), .inb(inb2),
    .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2), .rnd(rnd2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(out2)
  );

  msk_and_hpc2_pipe #(.d(3), .W(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .ina(ina3), .inb(inb3),
    .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3), .rnd(rnd3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out(out3)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] unmask2(input logic [7:0] x);
    return x[3:0] ^ x[7:4];
  endfunction

  function automatic logic [1:0] unmask3(input logic [5:0] x);
    return x[1:0] ^ x[3:2] ^ x[5:4];
  endfunction

  task automatic make2(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] ia, output logic [7:0] ib, output logic [3:0] r);
    logic [3:0] sa, sb;
    sa = 4'($urandom());
    sb = 4'($urandom());
    r  = 4'($urandom());
    ia = {a ^ sa, sa};
    ib = {b ^ sb, sb};
  endtask

  task automatic make3(input logic [1:0] a, input logic [1:0] b,
                       output logic [5:0] ia, output logic [5:0] ib, output logic [5:0] r);
    logic [1:0] a0, a1, b0, b1;
    a0 = 2'($urandom()); a1 = 2'($urandom());
    b0 = 2'($urandom()); b1 = 2'($urandom());
    r  = 6'($urandom());
    ia = {a ^ a0 ^ a1, a1, a0};
    ib = {b ^ b0 ^ b1, b1, b0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut2: queue of unmasked products, in acceptance order.
  logic [3:0] q2 [$];
  int n_out2 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) check("sb2_unexpected_out", 32'd1, 32'd0);
        else check("sb2_data", 32'(unmask2(out2)), 32'(q2.pop_front()));
        n_out2++;
      end
      if (in_valid2 && in_ready2) q2.push_back(unmask2(ina2) & unmask2(inb2));
`ifdef MSK_HPC2_CLEAR_EN
      if (!out_valid2) check("clear2_out_zero", 32'(out2), 32'd0);
`endif
    end
  end

  task automatic drain2();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (q2.size() == 0 && !out_valid2) done = 1'b1;
      else tick();
    end
    check("drain2_done", 32'(done), 32'd1);
    tick();
  endtask

  typedef struct packed {
    logic [7:0] ina;
    logic [7:0] inb;
    logic [3:0] rnd;
    logic [3:0] exp;
  } vec2_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] exp;
  } vec3_t;

  vec2_t      tv2 [6];
  vec3_t      tv3 [16];
  logic [3:0] ra, rb, first_exp;
  logic [7:0] first_out;
  logic [11:0] ov_hist;
  logic [1:0] q3 [$];
  int base, nfire, accepted, idx, n_got;
  bit fire_i, fire_o;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    tv2[0] = '{ina: 8'h93, inb: 8'h95, rnd: 4'h6, exp: 4'h8};
    tv2[1] = '{ina: 8'hF0, inb: 8'h0F, rnd: 4'hA, exp: 4'hF};
    tv2[2] = '{ina: 8'h55, inb: 8'h3C, rnd: 4'h3, exp: 4'h0};
    tv2[3] = '{ina: 8'h12, inb: 8'h47, rnd: 4'hF, exp: 4'h3};
    tv2[4] = '{ina: 8'hAB, inb: 8'hEF, rnd: 4'h5, exp: 4'h1};
    tv2[5] = '{ina: 8'h6C, inb: 8'h81, rnd: 4'h0, exp: 4'h8};
    for (int i = 0; i < 16; i++) begin
      tv3[i].a   = 2'(i >> 2);
      tv3[i].b   = 2'(i);
      tv3[i].exp = 2'(i >> 2) & 2'(i);
    end

    rst = 1'b1;
    in_valid2 = 1'b0; rnd_valid2 = 1'b1; out_ready2 = 1'b1;
    ina2 = '0; inb2 = '0; rnd2 = '0;
    in_valid3 = 1'b0; rnd_valid3 = 1'b1; out_ready3 = 1'b1;
    ina3 = '0; inb3 = '0; rnd3 = '0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid2), 32'd0);
    check("rst_out", 32'(out2), 32'd0);
    check("rst_in_ready", 32'(in_ready2), 32'd1);
    check("rst_rnd_ready", 32'(rnd_ready2), 32'd0);
    rnd_valid2 = 1'b0;
    #1 check("rst_in_ready_no_rnd", 32'(in_ready2), 32'd0);
    rnd_valid2 = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Directed vectors, one at a time, 2-cycle latency
    for (int v = 0; v < 6; v++) begin
      in_valid2 = 1'b1; ina2 = tv2[v].ina; inb2 = tv2[v].inb; rnd2 = tv2[v].rnd;
      @(negedge clk);
      check("t1_in_ready", 32'(in_ready2), 32'd1);
      check("t1_rnd_ready_c0", 32'(rnd_ready2), 32'd1);
      check("t1_out_valid_c0", 32'(out_valid2), 32'd0);
      tick();
      in_valid2 = 1'b0;
      @(negedge clk);
      check("t1_rnd_ready_c1", 32'(rnd_ready2), 32'd0);
      check("t1_out_valid_c1", 32'(out_valid2), 32'd0);
      tick();
      @(negedge clk);
      check("t1_out_valid_c2", 32'(out_valid2), 32'd1);
      check("t1_data", 32'(unmask2(out2)), 32'(tv2[v].exp));
      tick();
    end

    // Back-to-back stream of 8
    base = n_out2;
    ov_hist = '0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        in_valid2 = 1'b1;
        ra = 4'($urandom()); rb = 4'($urandom());
        make2(ra, rb, ina2, inb2, rnd2);
      end else begin
        in_valid2 = 1'b0;
      end
      @(negedge clk);
      ov_hist[k] = out_valid2;
      if (k < 8) check("t2_in_ready", 32'(in_ready2), 32'd1);
      tick();
    end
    check("t2_out_valid_pattern", 32'(ov_hist), 32'h3FC);
    check("t2_count", 32'(n_out2 - base), 32'd8);

    // Stall with out_ready low after three offered transfers
    base = n_out2;
    out_ready2 = 1'b0;
    accepted = 0;
    ra = 4'($urandom()); rb = 4'($urandom());
    first_exp = ra & rb;
    make2(ra, rb, ina2, inb2, rnd2);
    in_valid2 = 1'b1;
    first_out = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      fire_i = in_valid2 && in_ready2;
      if (k < 2) begin
        check("t3_in_ready_open", 32'(in_ready2), 32'd1);
      end else begin
        check("t3_in_ready_full", 32'(in_ready2), 32'd0);
        check("t3_rnd_ready_full", 32'(rnd_ready2), 32'd0);
        check("t3_out_valid", 32'(out_valid2), 32'd1);
        check("t3_first_data", 32'(unmask2(out2)), 32'(first_exp));
        if (k == 2) first_out = out2;
        else check("t3_out_stable", 32'(out2), 32'(first_out));
      end
      tick();
      if (fire_i) begin
        accepted++;
        ra = 4'($urandom()); rb = 4'($urandom());
        make2(ra, rb, ina2, inb2, rnd2);
      end
    end
    check("t3_accepted", 32'(accepted), 32'd2);
    out_ready2 = 1'b1;
    @(negedge clk);
    check("t3_release_in_ready", 32'(in_ready2), 32'd1);
    tick();
    in_valid2 = 1'b0;
    drain2();
    check("t3_count", 32'(n_out2 - base), 32'd3);

    // No randomness: nothing enters, earlier results still drain
    base = n_out2;
    nfire = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid2 = 1'b1;
      rnd_valid2 = (k < 2);
      if (k <= 2) begin
        ra = 4'($urandom()); rb = 4'($urandom());
        make2(ra, rb, ina2, inb2, rnd2);
      end
      @(negedge clk);
      if (k < 2) begin
        check("t4_in_ready_rnd", 32'(in_ready2), 32'd1);
      end else begin
        check("t4_in_ready_no_rnd", 32'(in_ready2), 32'd0);
        check("t4_rnd_ready_no_rnd", 32'(rnd_ready2), 32'd0);
        if (out_valid2 && out_ready2) nfire++;
      end
      tick();
    end
    check("t4_drained", 32'(nfire), 32'd2);
    rnd_valid2 = 1'b1;
    @(negedge clk);
    check("t4_resume_in_ready", 32'(in_ready2), 32'd1);
    tick();
    in_valid2 = 1'b0;
    drain2();
    check("t4_count", 32'(n_out2 - base), 32'd3);

    // Reset while both stages are full and stalled
    out_ready2 = 1'b0;
    in_valid2 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ra = 4'($urandom()); rb = 4'($urandom());
      make2(ra, rb, ina2, inb2, rnd2);
      @(negedge clk);
      check("t5_fill_in_ready", 32'(in_ready2), 32'd1);
      tick();
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    check("t5_full_out_valid", 32'(out_valid2), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 32'(out_valid2), 32'd0);
    check("t5_rst_out", 32'(out2), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready2), 32'd1);
    check("t5_rst_rnd_ready", 32'(rnd_ready2), 32'd0);
    q2.delete();
    tick();
    rst = 1'b0;
    out_ready2 = 1'b1;
    @(negedge clk);
    check("t5_post_out_valid", 32'(out_valid2), 32'd0);
    tick();
    in_valid2 = 1'b1; ina2 = tv2[3].ina; inb2 = tv2[3].inb; rnd2 = tv2[3].rnd;
    @(negedge clk);
    check("t5_in_ready", 32'(in_ready2), 32'd1);
    tick();
    in_valid2 = 1'b0;
    @(negedge clk);
    check("t5_out_valid_c1", 32'(out_valid2), 32'd0);
    tick();
    @(negedge clk);
    check("t5_out_valid_c2", 32'(out_valid2), 32'd1);
    check("t5_data", 32'(unmask2(out2)), 32'(tv2[3].exp));
    tick();

    // d=3: exhaustive unmasked values with random stalls on both handshakes
    idx = 0;
    n_got = 0;
    make3(tv3[0].a, tv3[0].b, ina3, inb3, rnd3);
    in_valid3 = 1'b1;
    for (int cyc = 0; cyc < 400 && n_got < 16; cyc++) begin
      rnd_valid3 = ($urandom_range(0, 3) != 0);
      out_ready3 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!rnd_valid3) check("t6_in_ready_no_rnd", 32'(in_ready3), 32'd0);
      if (!in_valid3) check("t6_rnd_ready_idle", 32'(rnd_ready3), 32'd0);
`ifdef MSK_HPC2_CLEAR_EN
      if (!out_valid3) check("clear3_out_zero", 32'(out3), 32'd0);
`endif
      fire_o = out_valid3 && out_ready3;
      if (fire_o) begin
        if (q3.size() == 0) check("t6_unexpected_out", 32'd1, 32'd0);
        else check("t6_data", 32'(unmask3(out3)), 32'(q3.pop_front()));
        n_got++;
      end
      fire_i = in_valid3 && in_ready3;
      if (fire_i) q3.push_back(tv3[idx].exp);
      tick();
      if (fire_i) begin
        idx++;
        if (idx < 16) make3(tv3[idx].a, tv3[idx].b, ina3, inb3, rnd3);
        else in_valid3 = 1'b0;
      end
    end
    check("t6_count", 32'(n_got), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msk_and_hpc2_pipe.md
Name: msk_and_hpc2_pipe

Overview:
- W-lane, d-share HPC2 masked AND with full inner-domain and cross-domain terms.
- Wraps the HPC2 register structure in a 2-stage valid/ready pipeline with a separate randomness handshake, so callers present both operands in the same cycle and may stall.
- Sits between masked S-box datapaths and randomness sources in the MSK gadget library; PINI at order d-1.

Parameters:
- d, 2, number of shares (>=2)
- W, 1, number of parallel AND lanes
- hpc2rnd, d*(d-1)/2, random bits per lane (derived localparam, not overridable)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand sharings valid
- in_ready  output  1  block accepts operands this cycle
- ina  input  d*W  sharing a; share i occupies bits [i*W +: W]
- inb  input  d*W  sharing b; same layout
- rnd_valid  input  1  fresh randomness available
- rnd_ready  output  1  randomness consumed this cycle
- rnd  input  W*hpc2rnd  lane k uses bits [k*hpc2rnd +: hpc2rnd]; pair (i<j) index i*d - i*(i+1)/2 + (j-1-i)
- out_valid  output  1  result sharing valid
- out_ready  input  1  downstream accepts result
- out  output  d*W  sharing a&b, same layout

Behaviour:
- Transfer-in: fire_in = in_valid && in_ready. in_ready = rnd_valid && (!vA || advA). rnd_ready = fire_in. Randomness never consumed without an operand transfer.
- Stage A (loaded on fire_in), per lane, per share i, per j!=i:
  - vA_reg[i][j] = inb[j] ^ r_ij
  - rA_reg[i][j] = r_ij
  - aA_reg[i] = ina[i]
  - bA_reg[i] = inb[i]
  - Valid flag vA is set on fire_in and cleared when advancing without a new fire_in.
- advA = vA && (!vB || fire_out). Stage B loads on advA:
  - u[i][j] = ~aA[i] & rA[i][j]
  - w[i][j] = aA[i] & vA_reg[i][j]
  - p[i] = aA[i] & bA[i]
- out share i = p[i] XOR (XOR over j!=i of u[i][j] ^ w[i][j]); combinational from stage B registers only, no input-to-output path.
- fire_out = out_valid && out_ready; out_valid = vB.
- Latency: out_valid exactly 2 cycles after fire_in when unstalled. Throughput: 1 result per cycle.
- Stall: with out_ready low, B holds. A holds if also full. in_ready drops only when both A and B are full. Values stay stable while out_valid && !out_ready.
- Simultaneous fire_out and advA: B takes new data. Simultaneous advA and fire_in: A takes new data. No bubble inserted.
- rnd_valid low: no transfer in; the pipeline keeps draining.
- Stage registers not loading hold their value.
- Reset (asynchronous, any time, including mid-stall): all stage registers, vA and vB go to 0. out = 0, out_valid = 0, in_ready = rnd_valid, rnd_ready = 0 while in_valid is low.
- Unmasked result per lane: XOR of out shares = (XOR of ina shares) & (XOR of inb shares).

Optional Feature:
- MSK_HPC2_CLEAR_EN defined: on any cycle where a stage does not load but its contents are passed on or discarded, that stage's data registers are zeroed. The stage holds its data only while stalled. out reads 0 whenever out_valid is 0. This prevents stale shares from recombining in glitchy downstream logic.
- Not defined: data registers load only on their enable and otherwise keep their value. out shows stale data while out_valid is 0.
- Handshake timing is identical in both builds.

Test Plan:
- d=2, W=4. ina shares 0x3/0x9, inb shares 0x5/0x9, rnd=0x6, all ready high -> out_valid 2 cycles later; out0^out1 = 0x8; rnd_ready pulsed once.
- Back-to-back stream of 8 random operand pairs, out_ready=1, rnd_valid=1 -> 8 consecutive out_valid cycles with correct unmasked AND; in_ready stays 1.
- Hold out_ready=0 after 3 transfers -> first result stable; in_ready low after 2 accepted; third waits with rnd_ready=0. Release -> results delivered in order, none lost.
- rnd_valid=0 with in_valid=1 for 5 cycles -> in_ready=0, rnd_ready=0, no transfer; pipeline drains previously accepted results.
- Assert rst for 1 cycle while both stages are full and stalled -> out_valid=0 and out=0 immediately. After release, a new transfer completes with 2-cycle latency.
- d=3, W=2, exhaustive unmasked a,b in {0..3} with random sharings and randomness -> out reconstructs a&b. With MSK_HPC2_CLEAR_EN, out=0 on every cycle with out_valid=0.
